// File: rtl/tpu_slot_timer.sv
`default_nettype none
// ==========================================================================
// tpu_slot_timer : TIME-driven slot/frame counter with periodic timer IRQ
// Rev 1.0
// ==========================================================================
module tpu_slot_timer #(
  parameter int TICKS_PER_SLOT = 16,
  parameter int NUM_SLOTS      = 256
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic        RSTTPU,
  input  logic        TIME,
  input  logic        TXSLOT_EN,
  input  logic        RXSLOT_EN,
  input  logic        TIMERINTMSK,
  input  logic [7:0]  TX_SLOT,
  input  logic [7:0]  RX_SLOT,
  input  logic [15:0] TIMER_INT_VALUE,
  input  logic        INT_CLR,
  output logic        TPUINT_RF,
  output logic [7:0]  SLOT_NUM,
  output logic        SLOT_START,
  output logic        FRAME_START,
  output logic        TX_ACTIVE,
  output logic        RX_ACTIVE
);

  localparam logic [7:0] TICK_MAX = 8'(TICKS_PER_SLOT - 1);
  localparam logic [7:0] SLOT_MAX = 8'(NUM_SLOTS - 1);

  logic        time_meta_q, time_sync_q, time_prev_q;
  logic        tick;
  logic        timer_evt;

  logic [7:0]  tick_cnt_q,    tick_cnt_d;
  logic [7:0]  slot_num_q,    slot_num_d;
  logic        slot_start_q,  slot_start_d;
  logic        frame_start_q, frame_start_d;
  logic        tx_active_q,   tx_active_d;
  logic        rx_active_q,   rx_active_d;
  logic [15:0] timer_cnt_q,   timer_cnt_d;
  logic        pend_q,        pend_d;

  // Synchronizer and edge register run through RSTTPU; only RST clears them.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      time_meta_q <= 1'b0;
      time_sync_q <= 1'b0;
      time_prev_q <= 1'b0;
    end else begin
      time_meta_q <= TIME;
      time_sync_q <= time_meta_q;
      time_prev_q <= time_sync_q;
    end
  end

  assign tick = time_sync_q & ~time_prev_q;

  always_comb begin
    tick_cnt_d    = tick_cnt_q;
    slot_num_d    = slot_num_q;
    slot_start_d  = 1'b0;
    frame_start_d = 1'b0;
    timer_cnt_d   = timer_cnt_q;
    timer_evt     = 1'b0;
    pend_d        = pend_q;

    // SLOT_NUM never exceeds NUM_SLOTS-1, so an out-of-range slot never matches.
    tx_active_d = TXSLOT_EN & (slot_num_q == TX_SLOT);
    rx_active_d = RXSLOT_EN & (slot_num_q == RX_SLOT);

    if (tick) begin
      if (tick_cnt_q == TICK_MAX) begin
        tick_cnt_d   = '0;
        slot_start_d = 1'b1;
        if (slot_num_q == SLOT_MAX) begin
          slot_num_d    = '0;
          frame_start_d = 1'b1;
        end else begin
          slot_num_d = slot_num_q + 8'd1;
        end
      end else begin
        tick_cnt_d = tick_cnt_q + 8'd1;
      end
    end

    // The >= compare reloads immediately if the period was lowered below the count.
    if (TIMER_INT_VALUE == 16'd0) begin
      timer_cnt_d = '0;
    end else if (tick) begin
      if (timer_cnt_q >= TIMER_INT_VALUE - 16'd1) begin
        timer_cnt_d = '0;
        timer_evt   = 1'b1;
      end else begin
        timer_cnt_d = timer_cnt_q + 16'd1;
      end
    end

    if (timer_evt && !TIMERINTMSK) begin
      pend_d = 1'b1;
    end else if (INT_CLR) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST || RSTTPU) begin
      tick_cnt_q    <= '0;
      slot_num_q    <= '0;
      slot_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      tx_active_q   <= 1'b0;
      rx_active_q   <= 1'b0;
      timer_cnt_q   <= '0;
      pend_q        <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      slot_num_q    <= slot_num_d;
      slot_start_q  <= slot_start_d;
      frame_start_q <= frame_start_d;
      tx_active_q   <= tx_active_d;
      rx_active_q   <= rx_active_d;
      timer_cnt_q   <= timer_cnt_d;
      pend_q        <= pend_d;
    end
  end

  assign TPUINT_RF   = pend_q;
  assign SLOT_NUM    = slot_num_q;
  assign SLOT_START  = slot_start_q;
  assign FRAME_START = frame_start_q;
  assign TX_ACTIVE   = tx_active_q;
  assign RX_ACTIVE   = rx_active_q;

endmodule
`default_nettype wire

// File: doc/tpu_slot_timer.md
TPU_SLOT_TIMER -- requirements
Module: tpu_slot_timer

Interface
REQ-001 SHALL have parameter TICKS_PER_SLOT, default 16, number of TIME ticks per slot (range 2..256).
REQ-002 SHALL have parameter NUM_SLOTS, default 256, slots per frame (range 2..256).
REQ-003 SHALL have port SYS_CLK  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port RSTTPU  in  1  soft reset pulse from the TPU control register.
REQ-006 SHALL have port TIME  in  1  asynchronous timebase square wave; each rising edge is one tick.
REQ-007 SHALL have port TXSLOT_EN  in  1  enables TX slot matching.
REQ-008 SHALL have port RXSLOT_EN  in  1  enables RX slot matching.
REQ-009 SHALL have port TIMERINTMSK  in  1  1 = timer interrupt masked.
REQ-010 SHALL have port TX_SLOT  in  8  slot number assigned to transmit.
REQ-011 SHALL have port RX_SLOT  in  8  slot number assigned to receive.
REQ-012 SHALL have port TIMER_INT_VALUE  in  16  timer interrupt period in ticks; 0 = timer disabled.
REQ-013 SHALL have port INT_CLR  in  1  one-cycle pulse that clears the pending interrupt.
REQ-014 SHALL have port TPUINT_RF  out  1  pending timer interrupt level, to the register file.
REQ-015 SHALL have port SLOT_NUM  out  8  current slot number.
REQ-016 SHALL have port SLOT_START  out  1  one-cycle pulse when SLOT_NUM advances.
REQ-017 SHALL have port FRAME_START  out  1  one-cycle pulse when SLOT_NUM wraps to 0.
REQ-018 SHALL have port TX_ACTIVE  out  1  high during the enabled TX slot.
REQ-019 SHALL have port RX_ACTIVE  out  1  high during the enabled RX slot.

Function
REQ-020 SHALL pass TIME through a 2-flop synchronizer, then a rising-edge detector; tick = 1-cycle pulse, 3 SYS_CLK cycles after the TIME rising edge.
REQ-021 SHALL count ticks in tick_cnt 0..TICKS_PER_SLOT-1; a tick at TICKS_PER_SLOT-1 wraps tick_cnt to 0 and advances the slot.
REQ-022 SHALL, on slot advance, update SLOT_NUM to SLOT_NUM+1, or to 0 when SLOT_NUM = NUM_SLOTS-1.
REQ-023 SHALL assert SLOT_START for exactly the first cycle SLOT_NUM holds its new value, and FRAME_START in that same cycle only when the new value is 0.
REQ-024 SHALL register TX_ACTIVE = TXSLOT_EN & (SLOT_NUM = TX_SLOT), 1-cycle latency from any operand change; RX_ACTIVE is identical using RXSLOT_EN and RX_SLOT.
REQ-025 SHALL keep TX_ACTIVE and RX_ACTIVE low for a TX_SLOT or RX_SLOT value >= NUM_SLOTS.
REQ-026 SHALL keep a 16-bit timer_cnt: on a tick, if timer_cnt >= TIMER_INT_VALUE-1 then timer_cnt <= 0 and a timer event fires; otherwise timer_cnt increments.
REQ-027 SHALL, when TIMER_INT_VALUE = 0, hold timer_cnt at 0 and fire no events.
REQ-028 SHALL, after TIMER_INT_VALUE is lowered below timer_cnt, fire an event and reload on the next tick (no 16-bit rollover).
REQ-029 SHALL set the pending flag on a timer event when TIMERINTMSK = 0; a masked event is discarded.
REQ-030 SHALL not clear an already pending flag when TIMERINTMSK is set.
REQ-031 SHALL clear the pending flag on INT_CLR; if an event and INT_CLR occur in the same cycle, set wins.
REQ-032 SHALL drive TPUINT_RF directly from the pending flag register.
REQ-033 SHALL continue tick, slot and timer counting in every cycle that RST and RSTTPU are low; the enables affect only the outputs.

Reset
REQ-034 SHALL, on RST, zero the synchronizer flops, edge register, tick_cnt, timer_cnt, pending flag, SLOT_NUM, SLOT_START, FRAME_START, TX_ACTIVE, RX_ACTIVE and TPUINT_RF.
REQ-035 SHALL treat RSTTPU = 1 like RST for everything except the synchronizer and edge register, which keep running.
REQ-036 SHALL give RST and RSTTPU priority over a coincident tick, event or INT_CLR; no SLOT_START or FRAME_START pulse is produced out of reset.

Verification
REQ-037 SHALL cover: TICKS_PER_SLOT=4, 4 TIME edges after reset -> SLOT_NUM=1 with one SLOT_START pulse, 3 cycles after the 4th edge.
REQ-038 SHALL cover: NUM_SLOTS=4, 16 ticks -> SLOT_NUM sequence 1,2,3,0, with FRAME_START only on the 0.
REQ-039 SHALL cover: TX_SLOT=2, TXSLOT_EN=1 -> TX_ACTIVE high for exactly the slot-2 duration, 1 cycle after SLOT_NUM=2; TXSLOT_EN=0 -> TX_ACTIVE stays low.
REQ-040 SHALL cover: TIMER_INT_VALUE=5, mask 0 -> TPUINT_RF rises after tick 5 and again after tick 10 once cleared; INT_CLR coincident with an event -> TPUINT_RF stays 1.
REQ-041 SHALL cover: TIMERINTMSK=1 across an event -> TPUINT_RF stays 0; TIMER_INT_VALUE=0 -> no interrupt after 100 ticks.
REQ-042 SHALL cover: RSTTPU pulse at mid-slot with an interrupt pending -> the next cycle shows SLOT_NUM=0, TPUINT_RF=0 and no SLOT_START, and counting resumes on the next tick.
